// File: rtl/closest_hit_resolver.sv
// Streaming closest-hit stage: min-t reduction over each tlast-delimited batch, one record per pixel into an output FIFO.
// Latency: record visible one edge after tlast is accepted; in_tready drops only when the output FIFO is full.
module closest_hit_resolver #(
  parameter int              SIZE      = 32,
  parameter int              IDX_W     = 4,
  parameter int              PAYLOAD_W = 192,
  parameter int              OUT_DEPTH = 4,
  parameter logic [SIZE-1:0] T_MIN     = 32'h3a83126f,
  parameter int              CNT_W     = 5
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [SIZE-1:0]      in_t,
  input  logic [IDX_W-1:0]     in_obj_idx,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_miss,
  input  logic                 in_tlast,
  input  logic [10:0]          in_hcount,
  input  logic [9:0]           in_vcount,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  output logic [SIZE-1:0]      out_t,
  output logic [IDX_W-1:0]     out_obj_idx,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_hit,
  output logic [CNT_W-1:0]     out_hit_count,
  output logic [10:0]          out_hcount,
  output logic [9:0]           out_vcount,
  output logic                 out_tvalid,
  input  logic                 out_tready
);

  localparam int EXP_W = (SIZE == 64) ? 11 : ((SIZE == 16) ? 5 : 8);
  localparam int MAN_W = SIZE - 1 - EXP_W;
  localparam logic [SIZE-1:0] FLOAT_MAX = {1'b0, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  localparam int AW = $clog2(OUT_DEPTH);

  typedef struct packed {
    logic [SIZE-1:0]      t;
    logic [IDX_W-1:0]     idx;
    logic [PAYLOAD_W-1:0] payload;
    logic                 hit;
    logic [CNT_W-1:0]     cnt;
    logic [10:0]          hcount;
    logic [9:0]           vcount;
  } rec_t;

  logic [SIZE-1:0]      best_t_q, best_t_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic [PAYLOAD_W-1:0] best_pl_q, best_pl_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 first_q, first_d;

  rec_t                 mem_q [OUT_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;

  logic                 in_fire, push, pop, fifo_full, fifo_empty;
  logic                 valid_hit, take;
  logic [SIZE-1:0]      base_t, res_t;
  logic [IDX_W-1:0]     base_idx, res_idx;
  logic [PAYLOAD_W-1:0] base_pl, res_pl;
  logic [CNT_W-1:0]     base_cnt, res_cnt;
  rec_t                 push_rec, head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_tready  = !fifo_full;
  assign in_fire    = in_tvalid && in_tready;
  assign push       = in_fire && in_tlast;
  assign pop        = out_tvalid && out_tready;

  // Positive finite floats order the same as their magnitude bits read as unsigned.
  always_comb begin
    valid_hit = !in_miss && !in_t[SIZE-1] && !(&in_t[SIZE-2 -: EXP_W]) &&
                (in_t[SIZE-2:0] > T_MIN[SIZE-2:0]);
    base_t    = first_q ? FLOAT_MAX : best_t_q;
    base_idx  = first_q ? '0 : best_idx_q;
    base_pl   = first_q ? '0 : best_pl_q;
    base_cnt  = first_q ? '0 : cnt_q;
    take      = valid_hit && (in_t[SIZE-2:0] < base_t[SIZE-2:0]);
    res_t     = take ? in_t : base_t;
    res_idx   = take ? in_obj_idx : base_idx;
    res_pl    = take ? in_payload : base_pl;
    res_cnt   = (valid_hit && !(&base_cnt)) ? base_cnt + CNT_W'(1) : base_cnt;
  end

  always_comb begin
    best_t_d   = best_t_q;
    best_idx_d = best_idx_q;
    best_pl_d  = best_pl_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    if (in_fire) begin
      if (in_tlast) begin
        best_t_d   = FLOAT_MAX;
        best_idx_d = '0;
        best_pl_d  = '0;
        cnt_d      = '0;
        first_d    = 1'b1;
      end else begin
        best_t_d   = res_t;
        best_idx_d = res_idx;
        best_pl_d  = res_pl;
        cnt_d      = res_cnt;
        first_d    = 1'b0;
      end
    end
  end

  always_comb begin
    push_rec         = '0;
    push_rec.t       = res_t;
    push_rec.idx     = res_idx;
    push_rec.payload = res_pl;
    push_rec.hit     = (res_cnt != '0);
    push_rec.cnt     = res_cnt;
    push_rec.hcount  = in_hcount;
    push_rec.vcount  = in_vcount;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      best_t_q   <= FLOAT_MAX;
      best_idx_q <= '0;
      best_pl_q  <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
    end else begin
      best_t_q   <= best_t_d;
      best_idx_q <= best_idx_d;
      best_pl_q  <= best_pl_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
    end
  end

  // Storage is cleared on reset so the idle head reads as all-zero data.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign out_tvalid    = !fifo_empty;
  assign out_t         = head.t;
  assign out_obj_idx   = head.idx;
  assign out_payload   = head.payload;
  assign out_hit       = head.hit;
  assign out_hit_count = head.cnt;
  assign out_hcount    = head.hcount;
  assign out_vcount    = head.vcount;

endmodule
